// File: rtl/sniffer_pkg.sv
// Shared TMDS sniffer definitions: control-token constants, alignment FSM
// states and the control-token matcher used by the aligner and the decoder.
package sniffer_pkg;

   localparam logic [9:0] CTRL_TOKEN_0 = 10'b1101010100;
   localparam logic [9:0] CTRL_TOKEN_1 = 10'b0010101011;
   localparam logic [9:0] CTRL_TOKEN_2 = 10'b0101010100;
   localparam logic [9:0] CTRL_TOKEN_3 = 10'b1010101011;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      SLIP,
      SETTLE,
      LOCKED
   } align_state_e;

   function automatic logic is_ctrl_token(input logic [9:0] w);
      return (w == CTRL_TOKEN_0) || (w == CTRL_TOKEN_1) ||
             (w == CTRL_TOKEN_2) || (w == CTRL_TOKEN_3);
   endfunction

endpackage

// File: rtl/tmds_token_detect.sv
// Control-token run detector: saturating run counter and a strobe on the word
// that completes a run of CTRL_RUN consecutive tokens.
module tmds_token_detect #(
   parameter int unsigned CTRL_RUN = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr_i,
   input  logic       valid_i,
   input  logic [9:0] word_i,
   output logic       run_done_o
);
   import sniffer_pkg::*;

   localparam int unsigned RW = $clog2(CTRL_RUN) + 1;

   logic [RW-1:0] run_cnt_q, run_cnt_d;
   logic          is_ctrl;

   assign is_ctrl = is_ctrl_token(word_i);

   // Strobe is independent of clr_i so the FSM can gate it without a loop.
   assign run_done_o = valid_i && is_ctrl && (run_cnt_q == RW'(CTRL_RUN - 1));

   always_comb begin
      run_cnt_d = run_cnt_q;
      if (clr_i) begin
         run_cnt_d = '0;
      end else if (valid_i) begin
         if (!is_ctrl)
            run_cnt_d = '0;
         else if (run_cnt_q != RW'(CTRL_RUN))
            run_cnt_d = run_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) run_cnt_q <= '0;
      else     run_cnt_q <= run_cnt_d;
   end

endmodule

// File: rtl/tmds_align_ctrl.sv
// TMDS channel word-alignment controller: hunts for control-token runs,
// issues bitslips until enough runs are seen, then forwards aligned words.
module tmds_align_ctrl #(
   parameter int unsigned SEARCH_WORDS = 4096,
   parameter int unsigned CTRL_RUN     = 8,
   parameter int unsigned LOCK_RUNS    = 4,
   parameter int unsigned SLIP_SETTLE  = 16,
   parameter int unsigned LOSS_WORDS   = 65536
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic       data_valid,
   input  logic [9:0] data_raw,
   output logic       bitslip,
   output logic       aligned,
   output logic [3:0] slip_count,
   output logic       data_ready,
   output logic [9:0] data_out
);
   import sniffer_pkg::*;

   localparam int unsigned WIN_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
   localparam int unsigned WW      = $clog2(WIN_MAX) + 1;
   localparam int unsigned RSW     = $clog2(LOCK_RUNS) + 1;
   localparam int unsigned STW     = $clog2(SLIP_SETTLE) + 1;

   align_state_e   state_q, state_d;
   logic [WW-1:0]  win_cnt_q, win_cnt_d;
   logic [RSW-1:0] runs_seen_q, runs_seen_d;
   logic [STW-1:0] settle_cnt_q, settle_cnt_d;
   logic [3:0]     slip_cnt_q, slip_cnt_d;
   logic           bitslip_q, aligned_q, data_ready_q;
   logic [9:0]     data_out_q;
   logic           run_done, det_clr, fwd;

   tmds_token_detect #(.CTRL_RUN(CTRL_RUN)) u_detect (
      .clk        (clk),
      .rst        (rst),
      .clr_i      (det_clr),
      .valid_i    (data_valid),
      .word_i     (data_raw),
      .run_done_o (run_done)
   );

   always_comb begin
      state_d      = state_q;
      win_cnt_d    = win_cnt_q;
      runs_seen_d  = runs_seen_q;
      settle_cnt_d = settle_cnt_q;
      slip_cnt_d   = slip_cnt_q;
      det_clr      = 1'b0;
      case (state_q)
         IDLE: begin
            win_cnt_d    = '0;
            runs_seen_d  = '0;
            settle_cnt_d = '0;
            det_clr      = 1'b1;
            state_d      = SEARCH;
         end
         SEARCH: begin
            if (data_valid) begin
               if (run_done) begin
                  win_cnt_d   = '0;
                  runs_seen_d = runs_seen_q + 1'b1;
                  if (runs_seen_q == RSW'(LOCK_RUNS - 1))
                     state_d = LOCKED;
               end else if (win_cnt_q == WW'(SEARCH_WORDS - 1)) begin
                  state_d = SLIP;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
               end
            end
         end
         SLIP: begin
            slip_cnt_d   = (slip_cnt_q == 4'd9) ? 4'd0 : slip_cnt_q + 4'd1;
            settle_cnt_d = '0;
            det_clr      = 1'b1;
            state_d      = SETTLE;
         end
         SETTLE: begin
            det_clr = 1'b1;
            if (settle_cnt_q == STW'(SLIP_SETTLE - 1)) begin
               settle_cnt_d = '0;
               win_cnt_d    = '0;
               runs_seen_d  = '0;
               state_d      = SEARCH;
            end else begin
               settle_cnt_d = settle_cnt_q + 1'b1;
            end
         end
         LOCKED: begin
            if (data_valid) begin
               if (run_done) begin
                  win_cnt_d = '0;
               end else if (win_cnt_q == WW'(LOSS_WORDS - 1)) begin
                  win_cnt_d   = '0;
                  runs_seen_d = '0;
                  det_clr     = 1'b1;
                  state_d     = SEARCH;
               end else begin
                  win_cnt_d = win_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Disable overrides every transition; only slip_count survives.
      if (!enable) begin
         state_d      = IDLE;
         win_cnt_d    = '0;
         runs_seen_d  = '0;
         settle_cnt_d = '0;
         slip_cnt_d   = slip_cnt_q;
         det_clr      = 1'b1;
      end
   end

   assign fwd = enable && (state_q == LOCKED) && data_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         win_cnt_q    <= '0;
         runs_seen_q  <= '0;
         settle_cnt_q <= '0;
         slip_cnt_q   <= '0;
         bitslip_q    <= 1'b0;
         aligned_q    <= 1'b0;
         data_ready_q <= 1'b0;
         data_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         win_cnt_q    <= win_cnt_d;
         runs_seen_q  <= runs_seen_d;
         settle_cnt_q <= settle_cnt_d;
         slip_cnt_q   <= slip_cnt_d;
         bitslip_q    <= (state_d == SLIP);
         aligned_q    <= (state_d == LOCKED);
         data_ready_q <= fwd;
         data_out_q   <= fwd ? data_raw : '0;
      end
   end

   assign bitslip    = bitslip_q;
   assign aligned    = aligned_q;
   assign slip_count = slip_cnt_q;
   assign data_ready = data_ready_q;
   assign data_out   = data_out_q;

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Directed bench for tmds_align_ctrl with small windows (64/8/4/16/128).
module tb_tmds_align_ctrl;

   localparam logic [9:0] TOK = 10'b1101010100;

   logic       clk = 1'b0;
   logic       rst, enable, data_valid;
   logic [9:0] data_raw;
   logic       bitslip, aligned, data_ready;
   logic [3:0] slip_count;
   logic [9:0] data_out;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tmds_align_ctrl #(
      .SEARCH_WORDS (64),
      .CTRL_RUN     (8),
      .LOCK_RUNS    (4),
      .SLIP_SETTLE  (16),
      .LOSS_WORDS   (128)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .data_valid (data_valid),
      .data_raw   (data_raw),
      .bitslip    (bitslip),
      .aligned    (aligned),
      .slip_count (slip_count),
      .data_ready (data_ready),
      .data_out   (data_out)
   );

   // Data words have at most two set bits, so no rotation of them is a token.
   function automatic logic [9:0] dword(input int unsigned i);
      logic [9:0] r;
      r = 10'h001 << (i % 9);
      return r | 10'h200;
   endfunction

   function automatic logic [9:0] rotl(input logic [9:0] w, input int unsigned k);
      return (w << k) | (w >> (10 - k));
   endfunction

   function automatic logic [9:0] blank28(input int unsigned p);
      return ((p % 28) < 8) ? TOK : dword(p);
   endfunction

   task automatic step(input logic v, input logic [9:0] w);
      data_valid = v;
      data_raw   = w;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0;
      step(1'b0, '0);
      step(1'b0, '0);
      rst = 1'b0;
   endtask

   task automatic begin_search();
      enable = 1'b1;
      step(1'b0, '0);
   endtask

   task automatic lock_up();
      for (int r = 0; r < 4; r++) begin
         if (r > 0) step(1'b1, dword(r));
         for (int t = 0; t < 8; t++) step(1'b1, TOK);
      end
   endtask

   task automatic test_reset();
      logic seen;
      do_reset();
      checks++; if (bitslip !== 1'b0) begin errors++; $display("FAIL rst_bitslip got=%b exp=0", bitslip); end
      checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL rst_aligned got=%b exp=0", aligned); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", data_ready); end
      checks++; if (slip_count !== 4'd0) begin errors++; $display("FAIL rst_slip_count got=%0d exp=0", slip_count); end
      checks++; if (data_out !== 10'd0) begin errors++; $display("FAIL rst_data_out got=%h exp=0", data_out); end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, (i % 9 == 8) ? dword(i) : TOK);
         if (aligned || bitslip || data_ready) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_quiet got=%b exp=0", seen); end
   endtask

   task automatic test_aligned_lock();
      logic seen;
      logic [9:0] w;
      do_reset();
      begin_search();
      seen = 1'b0;
      for (int r = 0; r < 4; r++) begin
         for (int t = 0; t < 8; t++) begin
            if (r == 3 && t == 7) begin
               checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL pre_lock got=%b exp=0", aligned); end
            end
            step(1'b1, TOK);
            if (bitslip) seen = 1'b1;
         end
         if (r < 3) for (int d = 0; d < 20; d++) begin
            step(1'b1, dword(d));
            if (bitslip) seen = 1'b1;
         end
      end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL lock_rise got=%b exp=1", aligned); end
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL lock_word_fwd got=%b exp=0", data_ready); end
      for (int i = 0; i < 10; i++) begin
         w = dword(i + 3);
         step(1'b1, w);
         checks++;
         if (data_ready !== 1'b1 || data_out !== w) begin
            errors++; $display("FAIL fwd_word%0d got=%b/%h exp=1/%h", i, data_ready, data_out, w);
         end
      end
      step(1'b0, dword(5));
      checks++;
      if (data_ready !== 1'b0 || data_out !== 10'd0) begin
         errors++; $display("FAIL fwd_idle got=%b/%h exp=0/000", data_ready, data_out);
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL aligned_no_slip got=%b exp=0", seen); end
   endtask

   task automatic test_shifted();
      int unsigned k, p, cyc, nslip;
      do_reset();
      begin_search();
      k = 7; p = 0; cyc = 0; nslip = 0;
      while (!aligned && cyc < 1000) begin
         step(1'b1, rotl(blank28(p), k));
         p++; cyc++;
         if (bitslip) begin
            nslip++;
            checks++;
            if (cyc != 64 + (nslip - 1) * 81) begin
               errors++; $display("FAIL shift_spacing%0d got=%0d exp=%0d", nslip, cyc, 64 + (nslip - 1) * 81);
            end
            k = (k + 1) % 10;
         end
      end
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL shift_lock_timeout got=%b exp=1", aligned); end
      checks++; if (nslip != 3) begin errors++; $display("FAIL shift_slips got=%0d exp=3", nslip); end
      checks++; if (slip_count !== 4'd3) begin errors++; $display("FAIL shift_slip_count got=%0d exp=3", slip_count); end
   endtask

   task automatic test_enable_drop();
      enable = 1'b0;
      step(1'b1, dword(1));
      checks++;
      if (aligned !== 1'b0 || data_ready !== 1'b0 || bitslip !== 1'b0 || data_out !== 10'd0) begin
         errors++; $display("FAIL dis_outputs got=%b%b%b/%h exp=000/000", aligned, data_ready, bitslip, data_out);
      end
      checks++; if (slip_count !== 4'd3) begin errors++; $display("FAIL dis_slip_kept got=%0d exp=3", slip_count); end
      step(1'b1, TOK);
      enable = 1'b1;
      step(1'b0, '0);
      for (int i = 0; i < 63; i++) step(1'b1, dword(i));
      checks++; if (bitslip !== 1'b0) begin errors++; $display("FAIL reen_early_slip got=%b exp=0", bitslip); end
      step(1'b1, dword(7));
      checks++; if (bitslip !== 1'b1) begin errors++; $display("FAIL reen_slip got=%b exp=1", bitslip); end
      step(1'b1, dword(8));
      checks++; if (slip_count !== 4'd4) begin errors++; $display("FAIL reen_slip_count got=%0d exp=4", slip_count); end
   endtask

   task automatic test_partial_runs();
      int unsigned p, cyc, nslip;
      logic seen;
      do_reset();
      begin_search();
      p = 0; cyc = 0; nslip = 0; seen = 1'b0;
      while (nslip < 10 && cyc < 1000) begin
         step(1'b1, ((p % 8) < 7) ? TOK : dword(p));
         p++; cyc++;
         if (aligned) seen = 1'b1;
         if (bitslip) begin
            nslip++;
            checks++;
            if (cyc != 64 + (nslip - 1) * 81) begin
               errors++; $display("FAIL part_spacing%0d got=%0d exp=%0d", nslip, cyc, 64 + (nslip - 1) * 81);
            end
            step(1'b1, ((p % 8) < 7) ? TOK : dword(p));
            p++; cyc++;
            checks++;
            if (slip_count !== 4'(nslip % 10)) begin
               errors++; $display("FAIL part_slip_count%0d got=%0d exp=%0d", nslip, slip_count, nslip % 10);
            end
         end
      end
      checks++; if (nslip != 10) begin errors++; $display("FAIL part_slips got=%0d exp=10", nslip); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL part_no_lock got=%b exp=0", seen); end
   endtask

   task automatic test_lock_loss();
      logic dropped, seen;
      do_reset();
      begin_search();
      lock_up();
      checks++; if (aligned !== 1'b1) begin errors++; $display("FAIL loss_setup got=%b exp=1", aligned); end
      dropped = 1'b0;
      for (int i = 0; i < 120; i++) begin
         step(1'b1, dword(i));
         if (!aligned) dropped = 1'b1;
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, TOK);
         if (!aligned) dropped = 1'b1;
      end
      checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL loss_run_priority got=%b exp=0", dropped); end
      seen = 1'b0;
      for (int i = 0; i < 127; i++) begin
         step(1'b1, dword(i));
         if (!aligned) dropped = 1'b1;
         if (bitslip) seen = 1'b1;
      end
      checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL loss_early got=%b exp=0", dropped); end
      step(1'b1, dword(2));
      checks++; if (aligned !== 1'b0) begin errors++; $display("FAIL loss_drop got=%b exp=0", aligned); end
      step(1'b1, dword(3));
      if (bitslip) seen = 1'b1;
      checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL loss_ready got=%b exp=0", data_ready); end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL loss_no_slip got=%b exp=0", seen); end
   endtask

   task automatic test_reset_in_settle();
      int unsigned cyc, nslip;
      do_reset();
      begin_search();
      cyc = 0; nslip = 0;
      while (nslip < 2 && cyc < 400) begin
         step(1'b1, dword(cyc));
         cyc++;
         if (bitslip) nslip++;
      end
      step(1'b1, dword(1));
      checks++; if (slip_count !== 4'd2) begin errors++; $display("FAIL settle_pre got=%0d exp=2", slip_count); end
      rst = 1'b1;
      step(1'b1, TOK);
      rst = 1'b0;
      checks++;
      if (bitslip !== 1'b0 || aligned !== 1'b0 || data_ready !== 1'b0 || data_out !== 10'd0 || slip_count !== 4'd0) begin
         errors++; $display("FAIL settle_rst got=%b%b%b/%h/%0d exp=000/000/0", bitslip, aligned, data_ready, data_out, slip_count);
      end
      step(1'b0, '0);
      for (int i = 0; i < 64; i++) step(1'b1, dword(i));
      checks++; if (bitslip !== 1'b1) begin errors++; $display("FAIL cut_setup got=%b exp=1", bitslip); end
      rst = 1'b1;
      step(1'b1, dword(4));
      rst = 1'b0;
      checks++;
      if (bitslip !== 1'b0 || slip_count !== 4'd0) begin
         errors++; $display("FAIL cut_pulse got=%b/%0d exp=0/0", bitslip, slip_count);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; data_valid = 1'b0; data_raw = '0;
      test_reset();
      test_aligned_lock();
      test_shifted();
      test_enable_drop();
      test_partial_runs();
      test_lock_loss();
      test_reset_in_settle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
